// File: rtl/rob_pkg.sv
// Shared types and default constants for the multi-commit reorder buffer.
// ROB_ENTRY field widths follow the default XLEN/PRF_LEN/AREG_LEN below.
package rob_pkg;

    localparam int ROB_DEPTH_DEF    = 32;
    localparam int COMMIT_WIDTH_DEF = 2;
    localparam int XLEN_DEF         = 32;
    localparam int PRF_LEN_DEF      = 6;
    localparam int AREG_LEN_DEF     = 5;

    function automatic int rob_len(input int depth);
        return $clog2(depth);
    endfunction

    localparam int ROB_LEN_DEF = rob_len(ROB_DEPTH_DEF);

    typedef struct packed {
        logic                    valid;
        logic                    completed;
        logic                    mis_pred;
        logic [XLEN_DEF-1:0]     target_pc;
        logic [XLEN_DEF-1:0]     pc;
        logic [AREG_LEN_DEF-1:0] areg;
        logic [PRF_LEN_DEF-1:0]  preg;
        logic                    has_dest;
    } ROB_ENTRY;

endpackage

// File: rtl/rob_commit_select.sv
// In-order retire selector: contiguous completed prefix of the head window,
// stopping after the first mispredicted entry, which is reported as the flush slot.
module rob_commit_select #(
    parameter int COMMIT_WIDTH = 2,
    parameter int SLOT_W       = 1
) (
    input  logic [COMMIT_WIDTH-1:0] win_valid,
    input  logic [COMMIT_WIDTH-1:0] win_completed,
    input  logic [COMMIT_WIDTH-1:0] win_mis_pred,
    output logic [COMMIT_WIDTH-1:0] commit_valid,
    output logic                    flush_hit,
    output logic [SLOT_W-1:0]       flush_slot
);

    logic run;

    always_comb begin
        commit_valid = '0;
        flush_hit    = 1'b0;
        flush_slot   = '0;
        run          = 1'b1;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            run             = run & win_valid[k] & win_completed[k];
            commit_valid[k] = run;
            if (run && win_mis_pred[k]) begin
                flush_hit  = 1'b1;
                flush_slot = SLOT_W'(k);
            end
            // a mispredicted entry retires, but nothing younger may follow it
            run = run & ~win_mis_pred[k];
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer retiring up to COMMIT_WIDTH instructions per cycle with full flush on mispredict.
// Optional perf counters are enabled by defining ROB_PERF_CNT_EN.
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter  int ROB_DEPTH    = ROB_DEPTH_DEF,
    parameter  int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
    parameter  int XLEN         = XLEN_DEF,
    parameter  int PRF_LEN      = PRF_LEN_DEF,
    parameter  int AREG_LEN     = AREG_LEN_DEF,
    localparam int ROB_LEN      = rob_len(ROB_DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         dispatch_enable,
    input  logic [XLEN-1:0]              dispatch_pc,
    input  logic [AREG_LEN-1:0]          dispatch_dest_areg_idx,
    input  logic [PRF_LEN-1:0]           dispatch_dest_preg_idx,
    input  logic                         dispatch_has_dest,
    output logic                         dispatch_ready,
    output logic [ROB_LEN-1:0]           rob_tail,
    input  logic                         cdb_valid,
    input  logic [ROB_LEN-1:0]           cdb_rob_idx,
    input  logic                         cdb_mis_pred,
    input  logic [XLEN-1:0]              cdb_target_pc,
    output logic [COMMIT_WIDTH-1:0]      commit_valid,
    output logic [COMMIT_WIDTH*AREG_LEN-1:0] commit_dest_areg_idx,
    output logic [COMMIT_WIDTH*PRF_LEN-1:0]  commit_dest_preg_idx,
    output logic [COMMIT_WIDTH-1:0]      commit_has_dest,
    output logic                         flush,
    output logic [XLEN-1:0]              flush_pc,
    output logic [ROB_LEN:0]             rob_count,
    output logic                         rob_empty,
    output logic                         rob_full
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_commit_cnt,
    output logic [31:0]                  perf_flush_cnt
`endif
);

    localparam int SLOT_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    ROB_ENTRY                rob_q [ROB_DEPTH];
    logic [ROB_LEN:0]        head_q;
    logic [ROB_LEN:0]        tail_q;
    logic [ROB_LEN:0]        count_q;
    logic [ROB_LEN-1:0]      head_idx;
    logic [ROB_LEN-1:0]      tail_idx;
    logic [ROB_LEN-1:0]      win_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] win_valid;
    logic [COMMIT_WIDTH-1:0] win_completed;
    logic [COMMIT_WIDTH-1:0] win_mis_pred;
    logic                    flush_hit;
    logic [SLOT_W-1:0]       flush_slot;
    logic [ROB_LEN:0]        n_commit;
    logic                    dispatch_fire;
    logic                    cdb_accept;

    assign head_idx       = head_q[ROB_LEN-1:0];
    assign tail_idx       = tail_q[ROB_LEN-1:0];
    assign rob_empty      = (head_q == tail_q);
    assign rob_full       = (head_idx == tail_idx) && (head_q[ROB_LEN] != tail_q[ROB_LEN]);
    assign rob_count      = count_q;
    assign rob_tail       = tail_idx;
    assign flush          = flush_hit;
    assign dispatch_ready = !rob_full && !flush_hit;
    assign dispatch_fire  = dispatch_enable && dispatch_ready;
    assign cdb_accept     = cdb_valid && rob_q[cdb_rob_idx].valid && !rob_q[cdb_rob_idx].completed;

    // head window, wrapping modulo ROB_DEPTH
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            win_idx[k]       = head_idx + ROB_LEN'(k);
            win_valid[k]     = rob_q[win_idx[k]].valid;
            win_completed[k] = rob_q[win_idx[k]].completed;
            win_mis_pred[k]  = rob_q[win_idx[k]].mis_pred;
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .SLOT_W       (SLOT_W)
    ) u_commit_select (
        .win_valid     (win_valid),
        .win_completed (win_completed),
        .win_mis_pred  (win_mis_pred),
        .commit_valid  (commit_valid),
        .flush_hit     (flush_hit),
        .flush_slot    (flush_slot)
    );

    always_comb begin
        n_commit             = '0;
        commit_dest_areg_idx = '0;
        commit_dest_preg_idx = '0;
        commit_has_dest      = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            n_commit = n_commit + {{ROB_LEN{1'b0}}, commit_valid[k]};
            if (commit_valid[k]) begin
                commit_dest_areg_idx[k*AREG_LEN +: AREG_LEN] = rob_q[win_idx[k]].areg;
                commit_dest_preg_idx[k*PRF_LEN +: PRF_LEN]   = rob_q[win_idx[k]].preg;
                commit_has_dest[k]                           = rob_q[win_idx[k]].has_dest;
            end
        end
        flush_pc = flush_hit ? rob_q[win_idx[flush_slot]].target_pc : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) rob_q[i].valid <= 1'b0;
        end else if (flush_hit) begin
            // squash everything; a same-cycle CDB is dropped and dispatch is blocked
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) rob_q[i].valid <= 1'b0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_valid[k]) rob_q[win_idx[k]].valid <= 1'b0;
            end
            if (cdb_accept) begin
                rob_q[cdb_rob_idx].completed <= 1'b1;
                rob_q[cdb_rob_idx].mis_pred  <= cdb_mis_pred;
                rob_q[cdb_rob_idx].target_pc <= cdb_target_pc;
            end
            if (dispatch_fire) begin
                rob_q[tail_idx] <= '{valid:     1'b1,
                                     completed: 1'b0,
                                     mis_pred:  1'b0,
                                     target_pc: '0,
                                     pc:        dispatch_pc,
                                     areg:      dispatch_dest_areg_idx,
                                     preg:      dispatch_dest_preg_idx,
                                     has_dest:  dispatch_has_dest};
            end
            head_q  <= head_q + n_commit;
            tail_q  <= tail_q + {{ROB_LEN{1'b0}}, dispatch_fire};
            count_q <= count_q + {{ROB_LEN{1'b0}}, dispatch_fire} - n_commit;
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            perf_commit_cnt <= perf_commit_cnt + 32'(n_commit);
            perf_flush_cnt  <= perf_flush_cnt + {31'd0, flush_hit};
        end
    end
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit (default parameters); checks perf counters when ROB_PERF_CNT_EN is defined.
module tb_rob_multi_commit;

    logic        clock = 1'b0;
    logic        reset;
    logic        dispatch_enable;
    logic [31:0] dispatch_pc;
    logic [4:0]  dispatch_dest_areg_idx;
    logic [5:0]  dispatch_dest_preg_idx;
    logic        dispatch_has_dest;
    logic        dispatch_ready;
    logic [4:0]  rob_tail;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_idx;
    logic        cdb_mis_pred;
    logic [31:0] cdb_target_pc;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_dest_areg_idx;
    logic [11:0] commit_dest_preg_idx;
    logic [1:0]  commit_has_dest;
    logic        flush;
    logic [31:0] flush_pc;
    logic [5:0]  rob_count;
    logic        rob_empty;
    logic        rob_full;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rob_multi_commit dut (
        .clock                  (clock),
        .reset                  (reset),
        .dispatch_enable        (dispatch_enable),
        .dispatch_pc            (dispatch_pc),
        .dispatch_dest_areg_idx (dispatch_dest_areg_idx),
        .dispatch_dest_preg_idx (dispatch_dest_preg_idx),
        .dispatch_has_dest      (dispatch_has_dest),
        .dispatch_ready         (dispatch_ready),
        .rob_tail               (rob_tail),
        .cdb_valid              (cdb_valid),
        .cdb_rob_idx            (cdb_rob_idx),
        .cdb_mis_pred           (cdb_mis_pred),
        .cdb_target_pc          (cdb_target_pc),
        .commit_valid           (commit_valid),
        .commit_dest_areg_idx   (commit_dest_areg_idx),
        .commit_dest_preg_idx   (commit_dest_preg_idx),
        .commit_has_dest        (commit_has_dest),
        .flush                  (flush),
        .flush_pc               (flush_pc),
        .rob_count              (rob_count),
        .rob_empty              (rob_empty),
        .rob_full               (rob_full)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt        (perf_commit_cnt),
        .perf_flush_cnt         (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset                  = 1'b0;
        dispatch_enable        = 1'b0;
        dispatch_pc            = '0;
        dispatch_dest_areg_idx = '0;
        dispatch_dest_preg_idx = '0;
        dispatch_has_dest      = 1'b0;
        cdb_valid              = 1'b0;
        cdb_rob_idx            = '0;
        cdb_mis_pred           = 1'b0;
        cdb_target_pc          = '0;
        tick();
        tick();
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_flush_pc", 64'(flush_pc), 64'd0);
        check("rst_tail", 64'(rob_tail), 64'd0);
        check("rst_count", 64'(rob_count), 64'd0);
        check("rst_empty", 64'(rob_empty), 64'd1);
        check("rst_full", 64'(rob_full), 64'd0);
        check("rst_ready", 64'(dispatch_ready), 64'd1);
        reset = 1'b1;

        // fill all 32 entries, then try a 33rd
        dispatch_enable   = 1'b1;
        dispatch_has_dest = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dispatch_pc            = 32'h1000 + 32'(4 * i);
            dispatch_dest_areg_idx = 5'(i);
            dispatch_dest_preg_idx = 6'(i);
            tick();
        end
        check("fill_full", 64'(rob_full), 64'd1);
        check("fill_ready", 64'(dispatch_ready), 64'd0);
        check("fill_count", 64'(rob_count), 64'd32);
        check("fill_tail", 64'(rob_tail), 64'd0);
        tick();
        check("over_count", 64'(rob_count), 64'd32);
        check("over_tail", 64'(rob_tail), 64'd0);
        dispatch_enable = 1'b0;

        // asynchronous reset in the middle of a cycle while full
        #2 reset = 1'b0;
        #1;
        check("async_rst_empty", 64'(rob_empty), 64'd1);
        check("async_rst_full", 64'(rob_full), 64'd0);
        check("async_rst_count", 64'(rob_count), 64'd0);
        check("async_rst_ready", 64'(dispatch_ready), 64'd1);
        tick();
        reset = 1'b1;

        // dispatch 0..3; a CDB in the same cycle as dispatch of idx 0 is dropped
        dispatch_enable = 1'b1;
        cdb_valid       = 1'b1;
        cdb_rob_idx     = 5'd0;
        for (int i = 0; i < 4; i++) begin
            dispatch_pc            = 32'h2000 + 32'(4 * i);
            dispatch_dest_areg_idx = 5'(i + 1);
            dispatch_dest_preg_idx = 6'(i + 10);
            dispatch_has_dest      = (i != 2);
            tick();
            cdb_valid = 1'b0;
        end
        dispatch_enable = 1'b0;
        check("ooo_count4", 64'(rob_count), 64'd4);
        check("ooo_drop_cdb", 64'(commit_valid), 64'd0);
        cdb_valid   = 1'b1;
        cdb_rob_idx = 5'd3;
        tick();
        check("ooo_cv_after3", 64'(commit_valid), 64'd0);
        cdb_rob_idx = 5'd1;
        tick();
        check("ooo_cv_after1", 64'(commit_valid), 64'd0);
        cdb_rob_idx = 5'd0;
        tick();
        check("ooo_cv_01", 64'(commit_valid), 64'b11);
        check("ooo_areg_01", 64'(commit_dest_areg_idx), 64'({5'd2, 5'd1}));
        check("ooo_preg_01", 64'(commit_dest_preg_idx), 64'({6'd11, 6'd10}));
        check("ooo_hd_01", 64'(commit_has_dest), 64'b11);
        check("ooo_flush0", 64'(flush), 64'd0);
        cdb_rob_idx = 5'd2;
        tick();
        check("ooo_cv_23", 64'(commit_valid), 64'b11);
        check("ooo_areg_23", 64'(commit_dest_areg_idx), 64'({5'd4, 5'd3}));
        check("ooo_hd_23", 64'(commit_has_dest), 64'b10);
        check("ooo_count2", 64'(rob_count), 64'd2);
        cdb_valid = 1'b0;
        tick();
        check("ooo_cv_done", 64'(commit_valid), 64'd0);
        check("ooo_empty", 64'(rob_empty), 64'd1);
        check("ooo_tail4", 64'(rob_tail), 64'd4);

        // mispredict on idx 1: 0 and 1 retire, flush to 0x400
        do_reset();
        dispatch_enable   = 1'b1;
        dispatch_has_dest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispatch_pc            = 32'h3000 + 32'(4 * i);
            dispatch_dest_areg_idx = 5'(i + 8);
            dispatch_dest_preg_idx = 6'(i + 30);
            tick();
        end
        dispatch_enable = 1'b0;
        cdb_valid       = 1'b1;
        cdb_rob_idx     = 5'd3;
        tick();
        cdb_rob_idx = 5'd2;
        tick();
        cdb_rob_idx   = 5'd1;
        cdb_mis_pred  = 1'b1;
        cdb_target_pc = 32'h400;
        tick();
        check("mp_cv_wait", 64'(commit_valid), 64'd0);
        cdb_rob_idx   = 5'd0;
        cdb_mis_pred  = 1'b0;
        cdb_target_pc = 32'h0;
        tick();
        check("mp_cv", 64'(commit_valid), 64'b11);
        check("mp_flush", 64'(flush), 64'd1);
        check("mp_flush_pc", 64'(flush_pc), 64'h400);
        check("mp_ready", 64'(dispatch_ready), 64'd0);
        // dispatch and CDB attempted during the flush cycle must both be dropped
        dispatch_enable = 1'b1;
        cdb_rob_idx     = 5'd2;
        tick();
        dispatch_enable = 1'b0;
        cdb_valid       = 1'b0;
        check("mp_post_flush", 64'(flush), 64'd0);
        check("mp_post_cv", 64'(commit_valid), 64'd0);
        check("mp_post_empty", 64'(rob_empty), 64'd1);
        check("mp_post_tail", 64'(rob_tail), 64'd0);
        check("mp_post_count", 64'(rob_count), 64'd0);
`ifdef ROB_PERF_CNT_EN
        check("perf_commit", 64'(perf_commit_cnt), 64'd2);
        check("perf_flush", 64'(perf_flush_cnt), 64'd1);
`endif
        tick();
        check("mp_never_cv", 64'(commit_valid), 64'd0);
        check("mp_never_empty", 64'(rob_empty), 64'd1);

        // mispredict in slot 0 blocks slot 1
        dispatch_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dispatch_dest_areg_idx = 5'(i + 20);
            tick();
        end
        dispatch_enable = 1'b0;
        cdb_valid       = 1'b1;
        cdb_rob_idx     = 5'd1;
        tick();
        cdb_rob_idx   = 5'd0;
        cdb_mis_pred  = 1'b1;
        cdb_target_pc = 32'h800;
        tick();
        cdb_valid    = 1'b0;
        cdb_mis_pred = 1'b0;
        check("mp0_cv", 64'(commit_valid), 64'b01);
        check("mp0_flush_pc", 64'(flush_pc), 64'h800);
        check("mp0_areg", 64'(commit_dest_areg_idx[4:0]), 64'd20);
        tick();
        check("mp0_empty", 64'(rob_empty), 64'd1);

        // move head to 30, then straddle the wrap boundary
        dispatch_enable = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        dispatch_enable = 1'b0;
        cdb_valid       = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cdb_rob_idx = 5'(i);
            tick();
        end
        cdb_valid = 1'b0;
        tick();
        check("wrap_pre_empty", 64'(rob_empty), 64'd1);
        check("wrap_pre_tail", 64'(rob_tail), 64'd30);
        dispatch_enable = 1'b1;
        for (int j = 0; j < 31; j++) begin
            dispatch_dest_areg_idx = 5'(j);
            dispatch_dest_preg_idx = 6'(j + 20);
            tick();
        end
        dispatch_enable = 1'b0;
        check("wrap_count31", 64'(rob_count), 64'd31);
        check("wrap_tail29", 64'(rob_tail), 64'd29);
        check("wrap_not_full", 64'(rob_full), 64'd0);
        check("wrap_ready", 64'(dispatch_ready), 64'd1);
        cdb_valid   = 1'b1;
        cdb_rob_idx = 5'd31;
        tick();
        check("wrap_cv_wait", 64'(commit_valid), 64'd0);
        cdb_rob_idx = 5'd30;
        tick();
        cdb_valid = 1'b0;
        check("wrap_cv", 64'(commit_valid), 64'b11);
        check("wrap_areg", 64'(commit_dest_areg_idx), 64'({5'd1, 5'd0}));
        check("wrap_preg", 64'(commit_dest_preg_idx), 64'({6'd21, 6'd20}));
        tick();
        check("wrap_count29", 64'(rob_count), 64'd29);
        check("wrap_cv_after", 64'(commit_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
